// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: edge-detects coin and button levels, keeps a single-digit credit,
// issues a one-cycle load pulse with the committed balance, and returns rejected or refunded
// coins through a one-cycle return pulse.
// Optional build macro: COIN_TIMEOUT_EN adds an idle counter that auto-refunds after
// TIMEOUT_CYCLES cycles without activity in ACCUM.
module coin_credit_accumulator #(
  parameter int unsigned MAX_CREDIT     = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       coin_1,
  input  logic       coin_2,
  input  logic       commit,
  input  logic       refund,
  output logic [3:0] credit,
  output logic [3:0] balance,
  output logic       load,
  output logic [3:0] coin_return,
  output logic       return_valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccum  = 2'b01,
    StCommit = 2'b10,
    StRefund = 2'b11
  } state_e;

  localparam logic [4:0] MaxSum = 5'(MAX_CREDIT);

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [3:0] balance_q, balance_d;
  logic       load_q, load_d;
  logic [3:0] coin_return_q, coin_return_d;
  logic       return_valid_q, return_valid_d;

  logic coin_1_q, coin_2_q, commit_q, refund_q;
  // Low for the first clock after reset release so levels already high are not counted.
  logic armed_q;

  logic coin_1_edge, coin_2_edge, commit_edge, refund_edge, any_edge;
  logic [4:0] coin_total;
  logic [4:0] sum;
  logic       timeout_fire;
  logic       refund_req;

  assign coin_1_edge = armed_q & coin_1 & ~coin_1_q;
  assign coin_2_edge = armed_q & coin_2 & ~coin_2_q;
  assign commit_edge = armed_q & commit & ~commit_q;
  assign refund_edge = armed_q & refund & ~refund_q;
  assign any_edge    = coin_1_edge | coin_2_edge | commit_edge | refund_edge;

  assign coin_total = 5'(coin_1_edge) + {3'b000, coin_2_edge, 1'b0};
  assign sum        = {1'b0, credit_q} + coin_total;

`ifdef COIN_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_cnt_q, idle_cnt_d;

  assign timeout_fire = (state_q == StAccum) && !any_edge && (idle_cnt_q == TimeoutLast);

  // Idle counter runs only while credit sits untouched in ACCUM.
  always_comb begin
    idle_cnt_d = idle_cnt_q + 16'd1;
    if ((state_q != StAccum) || any_edge || timeout_fire) begin
      idle_cnt_d = 16'd0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      idle_cnt_q <= 16'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_fire       = 1'b0;
`endif

  assign refund_req = refund_edge | timeout_fire;

  // Credit, payout and state decisions; refund outranks commit, which outranks plain coins.
  always_comb begin
    credit_d       = credit_q;
    balance_d      = balance_q;
    load_d         = 1'b0;
    coin_return_d  = 4'd0;
    return_valid_d = 1'b0;
    state_d        = StIdle;

    if (refund_req && (sum != 5'd0)) begin
      coin_return_d  = sum[3:0];
      return_valid_d = 1'b1;
      credit_d       = 4'd0;
      state_d        = StRefund;
    end else if (commit_edge && (sum != 5'd0)) begin
      load_d   = 1'b1;
      credit_d = 4'd0;
      state_d  = StCommit;
      if (sum <= MaxSum) begin
        balance_d = sum[3:0];
      end else begin
        // Overflowing coins bounce while the existing credit is still committed.
        balance_d      = credit_q;
        coin_return_d  = coin_total[3:0];
        return_valid_d = 1'b1;
      end
    end else begin
      if (sum <= MaxSum) begin
        credit_d = sum[3:0];
      end else begin
        coin_return_d  = coin_total[3:0];
        return_valid_d = 1'b1;
      end
      state_d = (credit_d != 4'd0) ? StAccum : StIdle;
    end
  end

  // All architectural state and registered outputs.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q        <= StIdle;
      credit_q       <= 4'd0;
      balance_q      <= 4'd0;
      load_q         <= 1'b0;
      coin_return_q  <= 4'd0;
      return_valid_q <= 1'b0;
      coin_1_q       <= 1'b0;
      coin_2_q       <= 1'b0;
      commit_q       <= 1'b0;
      refund_q       <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      balance_q      <= balance_d;
      load_q         <= load_d;
      coin_return_q  <= coin_return_d;
      return_valid_q <= return_valid_d;
      coin_1_q       <= coin_1;
      coin_2_q       <= coin_2;
      commit_q       <= commit;
      refund_q       <= refund;
      armed_q        <= 1'b1;
    end
  end

  assign credit       = credit_q;
  assign balance      = balance_q;
  assign load         = load_q;
  assign coin_return  = coin_return_q;
  assign return_valid = return_valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Self-checking bench for coin_credit_accumulator: directed scenarios with constant
// expectations, then randomized levels checked against a cycle-level behavioural model.
module tb_coin_credit_accumulator;

  localparam int MaxCredit = 9;
  localparam int Timeout   = 8;

  logic       clock;
  logic       clear_n;
  logic       coin_1, coin_2, commit, refund;
  logic [3:0] credit, balance, coin_return;
  logic       load, return_valid;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_credit, m_balance, m_ret, m_state, m_idle;
  bit m_load, m_rv, m_armed;
  bit p_c1, p_c2, p_cm, p_rf;

  coin_credit_accumulator #(
    .MAX_CREDIT    (MaxCredit),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .coin_1      (coin_1),
    .coin_2      (coin_2),
    .commit      (commit),
    .refund      (refund),
    .credit      (credit),
    .balance     (balance),
    .load        (load),
    .coin_return (coin_return),
    .return_valid(return_valid),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_credit = 0; m_balance = 0; m_ret = 0; m_state = 0; m_idle = 0;
    m_load = 0; m_rv = 0; m_armed = 0;
    p_c1 = 0; p_c2 = 0; p_cm = 0; p_rf = 0;
  endtask

  // One rising clock of the reference behaviour, given the levels present at that edge.
  task automatic model_clock(input bit c1, input bit c2, input bit cm, input bit rf);
    int coins, tot;
    bit e1, e2, ecm, erf, any, fire;
    e1  = m_armed && c1 && !p_c1;
    e2  = m_armed && c2 && !p_c2;
    ecm = m_armed && cm && !p_cm;
    erf = m_armed && rf && !p_rf;
    any = e1 || e2 || ecm || erf;
    fire = 0;
`ifdef COIN_TIMEOUT_EN
    fire = (m_state == 1) && !any && (m_idle == Timeout - 1);
    if (m_state == 1 && !any && !fire) m_idle = m_idle + 1;
    else m_idle = 0;
`endif
    coins = int'(e1) + 2 * int'(e2);
    tot   = m_credit + coins;
    m_load = 0; m_rv = 0; m_ret = 0;
    if ((erf || fire) && tot > 0) begin
      m_ret = tot; m_rv = 1; m_credit = 0; m_state = 3;
    end else if (ecm && tot > 0) begin
      m_load = 1; m_state = 2;
      if (tot <= MaxCredit) m_balance = tot;
      else begin
        m_balance = m_credit; m_ret = coins; m_rv = 1;
      end
      m_credit = 0;
    end else begin
      if (tot <= MaxCredit) m_credit = tot;
      else begin
        m_ret = coins; m_rv = 1;
      end
      m_state = (m_credit > 0) ? 1 : 0;
    end
    p_c1 = c1; p_c2 = c2; p_cm = cm; p_rf = rf;
    m_armed = 1;
  endtask

  // Drive levels, clock once, advance the model, and settle 1 time unit past the edge.
  task automatic cycle(input bit c1, input bit c2, input bit cm, input bit rf);
    coin_1 = c1; coin_2 = c2; commit = cm; refund = rf;
    @(posedge clock);
    model_clock(c1, c2, cm, rf);
    #1;
  endtask

  task automatic apply_reset(input bit c1);
    coin_1 = c1; coin_2 = 0; commit = 0; refund = 0;
    clear_n = 0;
    model_reset();
    @(posedge clock);
    #1;
    clear_n = 1;
  endtask

  task automatic test_reset();
    clear_n = 1; coin_1 = 0; coin_2 = 0; commit = 0; refund = 0;
    #2 clear_n = 0;
    #1;
    checks++; if (credit !== 4'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit); end
    checks++; if (balance !== 4'd0) begin errors++; $display("FAIL reset_balance: got %0d want 0", balance); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %0b want 0", load); end
    checks++; if (coin_return !== 4'd0) begin errors++; $display("FAIL reset_ret: got %0d want 0", coin_return); end
    checks++; if (return_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %0b want 0", return_valid); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    model_reset();
    @(posedge clock);
    #1 clear_n = 1;
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_accumulate();
    int exp_credit[3] = '{2, 4, 5};
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cycle(0, 1, 0, 0);
      else cycle(1, 0, 0, 0);
      checks++; if (credit !== 4'(exp_credit[i])) begin errors++; $display("FAIL accum_credit%0d: got %0d want %0d", i, credit, exp_credit[i]); end
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL accum_state%0d: got %0d want 1", i, state); end
      checks++; if (load !== 1'b0 || return_valid !== 1'b0) begin errors++; $display("FAIL accum_pulses%0d: got load=%0b rv=%0b want 0", i, load, return_valid); end
      cycle(0, 0, 0, 0);
    end
  endtask

  task automatic test_overflow();
    // From 5: +1 -> 6, +2 -> 8
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
    checks++; if (credit !== 4'd8) begin errors++; $display("FAIL ovf_pre: got %0d want 8", credit); end
    cycle(0, 1, 0, 0);
    checks++; if (credit !== 4'd8) begin errors++; $display("FAIL ovf_credit: got %0d want 8", credit); end
    checks++; if (coin_return !== 4'd2 || return_valid !== 1'b1) begin errors++; $display("FAIL ovf_return: got ret=%0d rv=%0b want ret=2 rv=1", coin_return, return_valid); end
    cycle(0, 1, 0, 0);
    checks++; if (coin_return !== 4'd0 || return_valid !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got ret=%0d rv=%0b want 0", coin_return, return_valid); end
    cycle(1, 0, 0, 0);
    checks++; if (credit !== 4'd9) begin errors++; $display("FAIL ovf_to9: got %0d want 9", credit); end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_priority();
    cycle(1, 0, 1, 1);
    checks++; if (coin_return !== 4'd10 || return_valid !== 1'b1) begin errors++; $display("FAIL prio_return: got ret=%0d rv=%0b want ret=10 rv=1", coin_return, return_valid); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL prio_load: got %0b want 0", load); end
    checks++; if (credit !== 4'd0 || state !== 2'b11) begin errors++; $display("FAIL prio_state: got credit=%0d state=%0d want 0/3", credit, state); end
    cycle(1, 0, 1, 1);
    checks++; if (state !== 2'b00 || return_valid !== 1'b0) begin errors++; $display("FAIL prio_after: got state=%0d rv=%0b want 0/0", state, return_valid); end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_commit();
    cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    checks++; if (balance !== 4'd5 || load !== 1'b1) begin errors++; $display("FAIL commit_load: got bal=%0d load=%0b want 5/1", balance, load); end
    checks++; if (state !== 2'b10 || credit !== 4'd0) begin errors++; $display("FAIL commit_state: got state=%0d credit=%0d want 2/0", state, credit); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0);
      checks++; if (load !== 1'b0 || state !== 2'b00 || balance !== 4'd5) begin errors++; $display("FAIL commit_hold%0d: got load=%0b state=%0d bal=%0d want 0/0/5", i, load, state, balance); end
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset_release();
    apply_reset(1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    checks++; if (credit !== 4'd0 || state !== 2'b00) begin errors++; $display("FAIL release_mask: got credit=%0d state=%0d want 0/0", credit, state); end
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); end
    cycle(1, 0, 0, 0);
    checks++; if (credit !== 4'd7) begin errors++; $display("FAIL release_build: got %0d want 7", credit); end
    // Start a commit so a load pulse is in flight, then reset mid-cycle.
    cycle(0, 0, 1, 0);
    #2 clear_n = 0;
    #1;
    checks++; if (credit !== 4'd0 || balance !== 4'd0 || load !== 1'b0) begin errors++; $display("FAIL async_clear: got credit=%0d bal=%0d load=%0b want 0", credit, balance, load); end
    checks++; if (coin_return !== 4'd0 || return_valid !== 1'b0 || state !== 2'b00) begin errors++; $display("FAIL async_clear2: got ret=%0d rv=%0b state=%0d want 0", coin_return, return_valid, state); end
    model_reset();
    @(posedge clock);
    #1 clear_n = 1;
    commit = 0; coin_1 = 0;
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    checks++; if (credit !== 4'd3) begin errors++; $display("FAIL to_build: got %0d want 3", credit); end
`ifdef COIN_TIMEOUT_EN
    for (int k = 1; k <= Timeout; k++) begin
      cycle(0, 0, 0, 0);
      checks++;
      if (return_valid !== (k == Timeout)) begin
        errors++; $display("FAIL to_rv%0d: got %0b want %0b", k, return_valid, (k == Timeout));
      end
    end
    checks++; if (coin_return !== 4'd3 || state !== 2'b11 || credit !== 4'd0) begin errors++; $display("FAIL to_refund: got ret=%0d state=%0d credit=%0d want 3/3/0", coin_return, state, credit); end
    cycle(0, 0, 0, 0);
`else
    for (int k = 0; k < 100; k++) cycle(0, 0, 0, 0);
    checks++; if (credit !== 4'd3 || state !== 2'b01 || return_valid !== 1'b0) begin errors++; $display("FAIL to_hold: got credit=%0d state=%0d rv=%0b want 3/1/0", credit, state, return_valid); end
`endif
  endtask

  task automatic test_random();
    bit c1, c2, cm, rf;
    apply_reset(0);
    for (int i = 0; i < 600; i++) begin
      c1 = ($urandom_range(0, 2) == 0);
      c2 = ($urandom_range(0, 2) == 0);
      cm = ($urandom_range(0, 6) == 0);
      rf = ($urandom_range(0, 9) == 0);
      if (i % 150 > 120) begin c1 = 0; c2 = 0; cm = 0; rf = 0; end
      cycle(c1, c2, cm, rf);
      checks++;
      if (credit !== 4'(m_credit) || balance !== 4'(m_balance) || load !== m_load ||
          coin_return !== 4'(m_ret) || return_valid !== m_rv || state !== 2'(m_state)) begin
        errors++;
        $display("FAIL random%0d: got cr=%0d bal=%0d ld=%0b ret=%0d rv=%0b st=%0d want cr=%0d bal=%0d ld=%0b ret=%0d rv=%0b st=%0d",
                 i, credit, balance, load, coin_return, return_valid, state,
                 m_credit, m_balance, m_load, m_ret, m_rv, m_state);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_accumulate();
    test_overflow();
    test_priority();
    test_commit();
    test_reset_release();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_credit_accumulator.md
# coin_credit_accumulator

Upstream front end of the vending controller. It turns raw coin-acceptor and button levels into a credited balance (0–9 dollars), and issues a one-cycle `load` pulse with `balance` to the downstream balance register when the customer commits. It also returns coins that would overflow the single-digit display, and refunds credit on request or, optionally, after inactivity.

## Interface
Parameters:
- MAX_CREDIT, 9, maximum credit held; must be ≤ 9 (single seven-segment digit)
- TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (16-bit counter; used only with COIN_TIMEOUT_EN)

Ports:
- clock  in  1  single clock, all state updates on rising edge
- clear_n  in  1  asynchronous active-low reset
- coin_1  in  1  level, high while acceptor sees a $1 coin; rising edge = one coin
- coin_2  in  1  level, $2 coin; rising edge = one coin
- commit  in  1  level button; rising edge transfers credit downstream
- refund  in  1  level button; rising edge returns all credit
- credit  out  4  running credit, for display
- balance  out  4  committed amount; valid when load=1, holds last value otherwise
- load  out  1  one-cycle pulse to downstream register load input
- coin_return  out  4  amount returned; valid when return_valid=1, else 0
- return_valid  out  1  one-cycle pulse
- state  out  2  00 IDLE, 01 ACCUM, 10 COMMIT, 11 REFUND

## Operation
- Edge detect: one registered copy per input; edge = in & ~in_q.
- In the first cycle after clear_n deasserts, edge detection is masked. The input registers load the current input levels, so a level already high at reset release does not count.
- Per cycle, the block forms sum = credit + 1·coin_1_edge + 2·coin_2_edge (5-bit).
- Priority when edges coincide: refund > commit > coins only.
- Coins only:
  - If sum ≤ MAX_CREDIT, credit := sum.
  - Otherwise all coins from this cycle are rejected: credit is unchanged, coin_return := coin total (1, 2 or 3), return_valid := 1.
- Refund edge:
  - If sum > 0, then coin_return := sum (max 12, fits 4 bits), return_valid := 1, credit := 0, and the block enters REFUND.
  - If sum = 0, nothing happens.
- Commit edge:
  - If sum ≤ MAX_CREDIT and sum > 0, then balance := sum, load := 1, credit := 0, and the block enters COMMIT.
  - If sum > MAX_CREDIT, then balance := credit and load := 1. The cycle's coins are rejected through coin_return/return_valid in the same cycle. credit := 0.
  - If sum = 0, the commit is ignored.
- State machine:
  - IDLE (credit = 0) → ACCUM when credit becomes > 0.
  - ACCUM → COMMIT on commit; ACCUM → REFUND on refund or timeout.
  - COMMIT and REFUND last exactly one cycle, then go to IDLE, or to ACCUM if that cycle's coins were credited.
- Coins in a COMMIT/REFUND cycle are processed normally against credit = 0.

## Timing
- Reset values: credit 0, balance 0, load 0, coin_return 0, return_valid 0, state IDLE, input registers 0, timeout counter 0.
- An input rise sampled at edge N updates credit, load, return_valid and state, visible after edge N (latency 1 clock).
- load and return_valid are registered pulses, high for exactly one cycle. They are never extended by held buttons; a new rising edge is required.
- Reset asserted mid-operation clears everything immediately. Any pending load or return pulse is dropped, and credit is lost.

## Configuration
- COIN_TIMEOUT_EN defined:
  - A 16-bit counter runs while in ACCUM.
  - Any coin, commit or refund edge resets it to 0.
  - Reaching TIMEOUT_CYCLES−1 triggers a refund identical to a refund edge, then the counter clears.
  - In IDLE the counter is held at 0.
- COIN_TIMEOUT_EN undefined:
  - No counter is built.
  - Credit is held indefinitely in ACCUM.

## Test plan
- Reset, then coin_2 edge, coin_2 edge, coin_1 edge → credit 2, 4, 5; state ACCUM; load and return_valid stay 0.
- Credit 8 plus coin_2 edge → credit stays 8; coin_return 2, return_valid one cycle. Then coin_1 edge → credit 9.
- Credit 5, then commit edge → next cycle balance 5, load = 1 for one cycle, state COMMIT, credit 0. Following cycle state IDLE and load 0. Holding commit high produces no second pulse.
- Credit 9, with refund and commit edges plus coin_1 edge in the same cycle → coin_return 10, return_valid = 1, load = 0, credit 0, state REFUND.
- coin_1 held high through clear_n release → no credit. Then clear_n low while credit 7 → all outputs 0 asynchronously.
- With COIN_TIMEOUT_EN and TIMEOUT_CYCLES = 8: credit 3, no activity → auto-refund coin_return 3 exactly 8 cycles after the last coin edge. Without the macro, credit is still 3 after 100 cycles.
